// File: rtl/la_hstx_pkg.sv
// rtl/la_hstx_pkg.sv - shared types for the four-phase req/ack source launcher
package la_hstx_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        DRAIN = 2'd0,
        IDLE  = 2'd1,
        REQ   = 2'd2,
        REL   = 2'd3
    } state_e;

endpackage

// File: rtl/la_hstx_sync.sv
// rtl/la_hstx_sync.sv - multi-flop level synchronizer with synchronous preset to 1
module la_hstx_sync #(
    parameter int    STAGES = 2,
    parameter string PROP   = "DEFAULT"
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d};
    end

    // Preset to 1 so a stale far-side acknowledge is never read as released.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= sync_d;
        end
    end

    // Named per-property block gives the library flow a hook to swap in hardened cells.
    generate
        if (PROP == "DEFAULT") begin : g_generic
            assign q = sync_q[STAGES-1];
        end else begin : g_mapped
            assign q = sync_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/la_hstx.sv
// rtl/la_hstx.sv - source-side launcher for a four-phase req/ack clock-domain crossing
module la_hstx
    import la_hstx_pkg::*;
#(
    parameter int    DW     = 32,
    parameter int    STAGES = 2,
    parameter string PROP   = "DEFAULT"
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          in_ready,
    output logic          tx_req,
    output logic [DW-1:0] tx_data,
    input  logic          tx_ack,
    output logic          busy
);

    logic          ack_s;
    state_e        state_q, state_d;
    logic          in_ready_q, in_ready_d;
    logic          tx_req_q, tx_req_d;
    logic [DW-1:0] tx_data_q, tx_data_d;

    la_hstx_sync #(
        .STAGES (STAGES),
        .PROP   (PROP)
    ) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (tx_ack),
        .q     (ack_s)
    );

    always_comb begin
        state_d   = state_q;
        tx_data_d = tx_data_q;
        unique case (state_q)
            DRAIN: begin
                tx_data_d = '0;
                if (!ack_s) state_d = IDLE;
            end
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    tx_data_d = in_data;
                    state_d   = REQ;
                end
            end
            REQ: begin
                if (ack_s) state_d = REL;
            end
            REL: begin
                if (!ack_s) state_d = IDLE;
            end
            default: state_d = DRAIN;
        endcase
        // Outputs are decoded from the next state so they toggle on the transition edge.
        in_ready_d = (state_d == IDLE);
        tx_req_d   = (state_d == REQ);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
            tx_req_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            tx_req_q   <= tx_req_d;
        end
    end

    // Cleared while draining, so it reads 0 one edge after reset lands in DRAIN.
    always_ff @(posedge clk) begin
        tx_data_q <= tx_data_d;
    end

    assign in_ready = in_ready_q;
    assign tx_req   = tx_req_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != IDLE);

endmodule
